// File: rtl/fetch_unit_if.sv
// Signal bundle around fetch_unit: instruction-memory read port, core redirect, decode handshake.
// master = fetch_unit side, slave = memory/core/decode side.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            out_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect_valid, redirect_pc,
        output out_valid, out_pc, out_instr,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect_valid, redirect_pc,
        input  out_valid, out_pc, out_instr,
        output out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem reads, 2-entry {pc, instr} queue to decode.
// Optional FETCH_PERF_EN adds the fetch_count output (accepted-instruction counter).
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  fetch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    state_e          state_q, state_d;
    logic [1:0]      count_q, count_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    entry_t          head_q, head_d;
    entry_t          tail_q, tail_d;

    logic            pop;
    logic            push;
    logic            outstanding_next;
    logic            issue;
    logic [1:0]      count_after_pop;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    assign pop  = (count_q != 2'd0) && bus.out_ready;
    // Only a WAIT-state ack without a simultaneous redirect carries data worth keeping.
    assign push = (state_q == WAIT) && bus.imem_ack && !bus.redirect_valid;

    // NOTE: combinational blocks assign every output a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        head_d          = head_q;
        tail_d          = tail_q;
        count_after_pop = count_q - {1'b0, pop};
        if (pop) begin
            head_d = tail_q;
        end
        if (push) begin
            if (count_after_pop == 2'd0) begin
                head_d = entry_t'{pc: addr_q, instr: bus.imem_rdata};
            end else begin
                tail_d = entry_t'{pc: addr_q, instr: bus.imem_rdata};
            end
        end
        if (bus.redirect_valid) begin
            count_d = 2'd0;
        end else begin
            count_d = count_after_pop + {1'b0, push};
        end
    end

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        outstanding_next = 1'b0;
        if (state_q != IDLE) begin
            outstanding_next = !bus.imem_ack;
        end

        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        // Never let the queue plus in-flight reads exceed its two slots.
        issue = !outstanding_next && (count_d != 2'd2);

        case (state_q)
            IDLE: begin
                if (issue) state_d = WAIT;
            end
            WAIT: begin
                if (bus.imem_ack) begin
                    state_d = issue ? WAIT : IDLE;
                end else if (bus.redirect_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.imem_ack) state_d = issue ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_d  = outstanding_next || issue;
        addr_d = issue ? fetch_pc_d : addr_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= 2'd0;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            // NOTE: queue storage is reset because the head drives out_pc/out_instr directly
            // and those must read zero out of reset.
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_pc    = head_q.pc;
    assign bus.out_instr = head_q.instr;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 32'd0;
        end else if (pop) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder with programmable latency plus a
// {pc, instr} scoreboard filled on kept acks and drained on decode handshakes.
module tb_fetch_unit;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(XLEN)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
`endif

    fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        exp_q[$];
    bit          ready_r, redir_v;
    logic [31:0] redir_pc;
    int          mem_lat, wait_cnt, n_acks, n_pops;
    bit          tainted, prev_pending, seen_out40, seen_req40;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'd3) + 32'h0000_1013;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tb_clear();
        exp_q.delete();
        tainted      = 1'b0;
        wait_cnt     = 0;
        n_acks       = 0;
        n_pops       = 0;
        prev_pending = 1'b0;
    endtask

    // One clock: drive inputs for the current cycle, account for the edge, sample #1 after it.
    task automatic tick();
        bus.out_ready      = ready_r;
        bus.redirect_valid = redir_v;
        bus.redirect_pc    = redir_pc;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = mem_word(bus.imem_addr);
        if (reset) begin
            tb_clear();
        end else begin
            if (bus.imem_req) begin
                if (bus.imem_addr == 32'h40) seen_req40 = 1'b1;
                if (wait_cnt >= mem_lat) begin
                    bus.imem_ack = 1'b1;
                    wait_cnt     = 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_pops++;
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e = exp_q.pop_front();
                    check("sb_pc", bus.out_pc, e.pc);
                    check("sb_instr", bus.out_instr, e.instr);
                end
            end
            if (bus.out_valid && bus.out_pc == 32'h40) seen_out40 = 1'b1;
            if (redir_v) begin
                exp_q.delete();
                if (bus.imem_req) tainted = 1'b1;
            end
            if (bus.imem_ack) begin
                n_acks++;
                if (!tainted) exp_q.push_back(exp_t'{pc: bus.imem_addr, instr: bus.imem_rdata});
                tainted = 1'b0;
            end
            prev_pending = bus.imem_req && !bus.imem_ack;
            prev_addr    = bus.imem_addr;
        end
        @(posedge clk);
        #1;
        if (prev_pending) begin
            check("req_hold", bus.imem_req, 1);
            check("addr_hold", bus.imem_addr, prev_addr);
        end
    endtask

    task automatic reset_dut();
        reset   = 1'b1;
        redir_v = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tb_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        reset    = 1'b1;
        ready_r  = 1'b0;
        redir_v  = 1'b0;
        redir_pc = 32'h0;
        mem_lat  = 0;
        seen_out40 = 1'b0;
        seen_req40 = 1'b0;
        tb_clear();
        repeat (3) tick();

        // Reset values
        check("rst_req", bus.imem_req, 0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_pc", bus.out_pc, 32'h0);
        check("rst_instr", bus.out_instr, 32'h0);

        // Free-running memory: one instruction per cycle from two cycles after release
        reset   = 1'b0;
        ready_r = 1'b1;
        tick();
        check("first_req", bus.imem_req, 1);
        check("first_addr", bus.imem_addr, 32'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("stream_valid", bus.out_valid, 1);
            check("stream_pc", bus.out_pc, 32'(4 * k));
            tick();
        end

        // Decode stall: queue fills with two reads, then resumes without a request gap
        ready_r = 1'b0;
        mem_lat = 0;
        reset_dut();
        repeat (6) tick();
        check("stall_reads", n_acks, 2);
        check("stall_req", bus.imem_req, 0);
        check("stall_valid", bus.out_valid, 1);
        check("stall_pc", bus.out_pc, 32'h0);
        ready_r = 1'b1;
        tick();
        check("resume_pc4", bus.out_pc, 32'h4);
        check("resume_req", bus.imem_req, 1);
        check("resume_addr", bus.imem_addr, 32'h8);
        tick();
        check("resume_pc8", bus.out_pc, 32'h8);

        // Redirect while WAIT with a late ack: data dropped, fetch resumes at 0x100
        mem_lat = 3;
        ready_r = 1'b1;
        reset_dut();
        tick();
        check("late_req", bus.imem_req, 1);
        redir_v  = 1'b1;
        redir_pc = 32'h103;
        tick();
        redir_v = 1'b0;
        g = 0;
        while (n_acks == 0 && g < 20) begin tick(); g++; end
        check("late_ack_seen", n_acks, 1);
        check("late_new_req", bus.imem_req, 1);
        check("late_new_addr", bus.imem_addr, 32'h100);
        g = 0;
        while (!bus.out_valid && g < 20) begin tick(); g++; end
        check("late_out_valid", bus.out_valid, 1);
        check("late_out_pc", bus.out_pc, 32'h100);

        // Two redirects while draining: last one wins, 0x40 never fetched or presented
        reset_dut();
        seen_out40 = 1'b0;
        seen_req40 = 1'b0;
        tick();
        redir_v  = 1'b1;
        redir_pc = 32'h40;
        tick();
        redir_pc = 32'h80;
        tick();
        redir_v = 1'b0;
        g = 0;
        while (n_acks == 0 && g < 20) begin tick(); g++; end
        check("drain_addr", bus.imem_addr, 32'h80);
        check("drain_req", bus.imem_req, 1);
        g = 0;
        while (!bus.out_valid && g < 20) begin tick(); g++; end
        check("drain_out_pc", bus.out_pc, 32'h80);
        repeat (12) tick();
        check("no_out_40", seen_out40, 0);
        check("no_req_40", seen_req40, 0);

        // Reset with a read outstanding and the queue occupied
        ready_r = 1'b0;
        mem_lat = 2;
        reset_dut();
        g = 0;
        while (!(n_acks >= 1 && bus.imem_req) && g < 20) begin tick(); g++; end
        check("pre_rst_valid", bus.out_valid, 1);
        check("pre_rst_req", bus.imem_req, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_req", bus.imem_req, 0);
        reset = 1'b0;
        tb_clear();
        tick();
        check("restart_req", bus.imem_req, 1);
        check("restart_addr", bus.imem_addr, 32'h0);

        // Idle redirect with a full queue and a handshake in the same cycle; PC wrap
        ready_r = 1'b0;
        mem_lat = 0;
        reset_dut();
        repeat (5) tick();
        check("full_idle_req", bus.imem_req, 0);
        ready_r  = 1'b1;
        redir_v  = 1'b1;
        redir_pc = 32'hFFFF_FFFE;
        tick();
        redir_v = 1'b0;
        check("idle_redir_req", bus.imem_req, 1);
        check("idle_redir_addr", bus.imem_addr, 32'hFFFF_FFFC);
        check("flushed_valid", bus.out_valid, 0);
        tick();
        check("wrap_valid", bus.out_valid, 1);
        check("wrap_pc_hi", bus.out_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc_zero", bus.out_pc, 32'h0);
        tick();

`ifdef FETCH_PERF_EN
        // Accepted-instruction counter, including wrap from all-ones
        ready_r = 1'b1;
        mem_lat = 0;
        reset_dut();
        check("perf_reset", fetch_count, 32'd0);
        g = 0;
        while (n_pops < 10 && g < 100) begin tick(); g++; end
        check("perf_ten", fetch_count, 32'd10);
        check("perf_valid", bus.out_valid, 1);
        dut.fetch_count_q = 32'hFFFF_FFFF;
        tick();
        check("perf_wrap", fetch_count, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
